// File: rtl/rv32i_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_ctrl_pkg
// Shared definitions for the rv32i multi-cycle control path:
//   - seq_state_t   : sequencer state encoding
//   - UNIT_*        : decoder execution-unit class codes (3 bits)
//   - CAUSE_*       : trap cause codes (2 bits)
//   - DEFAULT_*     : default reset / trap vectors
//   - is_legal_unit : true for the four implemented unit classes
// ---------------------------------------------------------------------------
package rv32i_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_COMMIT  = 3'd3,
      ST_TRAP    = 3'd4
   } seq_state_t;

   localparam logic [2:0] UNIT_ALU    = 3'd0;
   localparam logic [2:0] UNIT_JAL    = 3'd1;
   localparam logic [2:0] UNIT_JALR   = 3'd2;
   localparam logic [2:0] UNIT_BRANCH = 3'd3;

   localparam logic [1:0] CAUSE_NONE       = 2'd0;
   localparam logic [1:0] CAUSE_MISALIGNED = 2'd1;
   localparam logic [1:0] CAUSE_ILLEGAL    = 2'd2;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

   function automatic logic is_legal_unit(input logic [2:0] sel);
      return (sel <= UNIT_BRANCH);
   endfunction

endpackage

// File: rtl/pc_target_select.sv
// ---------------------------------------------------------------------------
// pc_target_select
// Combinational next-PC selection for the sequencer.
// Ports:
//   pc            in  32  current architectural PC
//   unit_sel      in  3   latched unit class of the instruction in flight
//   jump_target   in  32  jal/jalr unit result
//   branch_taken  in  1   branch unit decision
//   branch_target in  32  branch unit target
//   next_pc       out 32  selected target (jalr LSB already cleared)
//   misaligned    out 1   selected target is not 4-byte aligned (bit1 set)
// ---------------------------------------------------------------------------
module pc_target_select
   import rv32i_ctrl_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [2:0]  unit_sel,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   logic [31:0] pc_plus4;

   // Wraps modulo 2^32 naturally through the 32-bit add.
   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      next_pc = pc_plus4;
      case (unit_sel)
         UNIT_JAL:    next_pc = jump_target;
         UNIT_JALR:   next_pc = {jump_target[31:1], 1'b0};
         UNIT_BRANCH: next_pc = branch_taken ? branch_target : pc_plus4;
         default:     next_pc = pc_plus4;
      endcase
   end

   // Only bit1 is checked: bit0 is architecturally cleared for jalr and the
   // 16-bit alignment case is not supported by this core.
   assign misaligned = next_pc[1];

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Multi-cycle control sequencer: FETCH -> DECODE -> EXECUTE -> COMMIT, with a
// TRAP state for illegal classes and misaligned control-flow targets.
// Every output is a register loaded from the decision made in the current
// state, so an output appears in the cycle after the state that produced it
// (fetch_enable in cycle 1, unit enable in cycle 3, commit effects in cycle 4).
// Ports:
//   clock, reset (async, active-high)
//   stall             in   instruction memory not ready, holds FETCH
//   instr_valid       in   decoder output valid, DECODE waits on it
//   unit_select       in   decoder class (0 alu, 1 jal, 2 jalr, 3 branch)
//   jump_target       in   jal/jalr result, used in COMMIT
//   branch_taken      in   branch result, used in COMMIT
//   branch_target     in   branch target, used in COMMIT
//   pc                out  architectural PC
//   fetch_enable      out  instruction request at pc
//   alu_enable / alu_unconditional_jal_enable /
//   alu_unconditional_jalr_enable / alu_branch_enable  out  one-hot unit enables
//   rd_write_enable   out  register-file write strobe
//   trap              out  one-cycle trap pulse
//   trap_cause        out  code of the most recent trap (sticky)
//   retired_count     out  retired-instruction counter
// Handshake: stall and instr_valid are level-sensitive qualifiers sampled on
// the rising clock edge; the sequencer advances past FETCH only on an edge with
// stall=0 and past DECODE only on an edge with instr_valid=1.
// ---------------------------------------------------------------------------
module pc_sequencer
   import rv32i_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        instr_valid,
   input  logic [2:0]  unit_select,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] pc,
   output logic        fetch_enable,
   output logic        alu_enable,
   output logic        alu_unconditional_jal_enable,
   output logic        alu_unconditional_jalr_enable,
   output logic        alu_branch_enable,
   output logic        rd_write_enable,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [31:0] retired_count
);

   seq_state_t  state_q, state_d;
   logic [2:0]  unit_q, unit_d;
   logic [1:0]  pending_cause_q, pending_cause_d;

   logic [31:0] pc_d;
   logic        fetch_d;
   logic        alu_d, jal_d, jalr_d, branch_d;
   logic        rd_we_d;
   logic        trap_d;
   logic [1:0]  trap_cause_d;
   logic [31:0] count_d;

   logic [31:0] target_pc;
   logic        target_misaligned;

   pc_target_select u_target (
      .pc            (pc),
      .unit_sel      (unit_q),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .next_pc       (target_pc),
      .misaligned    (target_misaligned)
   );

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q                       <= ST_FETCH;
         unit_q                        <= UNIT_ALU;
         pending_cause_q               <= CAUSE_NONE;
         pc                            <= RESET_VECTOR;
         fetch_enable                  <= 1'b0;
         alu_enable                    <= 1'b0;
         alu_unconditional_jal_enable  <= 1'b0;
         alu_unconditional_jalr_enable <= 1'b0;
         alu_branch_enable             <= 1'b0;
         rd_write_enable               <= 1'b0;
         trap                          <= 1'b0;
         trap_cause                    <= CAUSE_NONE;
         retired_count                 <= 32'd0;
      end else begin
         state_q                       <= state_d;
         unit_q                        <= unit_d;
         pending_cause_q               <= pending_cause_d;
         pc                            <= pc_d;
         fetch_enable                  <= fetch_d;
         alu_enable                    <= alu_d;
         alu_unconditional_jal_enable  <= jal_d;
         alu_unconditional_jalr_enable <= jalr_d;
         alu_branch_enable             <= branch_d;
         rd_write_enable               <= rd_we_d;
         trap                          <= trap_d;
         trap_cause                    <= trap_cause_d;
         retired_count                 <= count_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d         = state_q;
      unit_d          = unit_q;
      pending_cause_d = pending_cause_q;
      pc_d            = pc;
      fetch_d         = 1'b0;
      alu_d           = 1'b0;
      jal_d           = 1'b0;
      jalr_d          = 1'b0;
      branch_d        = 1'b0;
      rd_we_d         = 1'b0;
      trap_d          = 1'b0;
      trap_cause_d    = trap_cause;
      count_d         = retired_count;

      case (state_q)
         ST_FETCH: begin
            fetch_d = 1'b1;
            if (!stall) begin
               state_d = ST_DECODE;
            end
         end

         ST_DECODE: begin
            if (instr_valid) begin
               unit_d = unit_select;
               if (is_legal_unit(unit_select)) begin
                  state_d = ST_EXECUTE;
               end else begin
                  pending_cause_d = CAUSE_ILLEGAL;
                  state_d         = ST_TRAP;
               end
            end
         end

         ST_EXECUTE: begin
            // unit_q is always legal here, so exactly one enable fires.
            case (unit_q)
               UNIT_ALU:    alu_d    = 1'b1;
               UNIT_JAL:    jal_d    = 1'b1;
               UNIT_JALR:   jalr_d   = 1'b1;
               UNIT_BRANCH: branch_d = 1'b1;
               default:     ;
            endcase
            state_d = ST_COMMIT;
         end

         ST_COMMIT: begin
            if (target_misaligned) begin
               // Instruction does not retire: pc, rd and count untouched.
               pending_cause_d = CAUSE_MISALIGNED;
               state_d         = ST_TRAP;
            end else begin
               pc_d    = target_pc;
               rd_we_d = (unit_q != UNIT_BRANCH);
               count_d = retired_count + 32'd1;
               state_d = ST_FETCH;
            end
         end

         ST_TRAP: begin
            trap_d       = 1'b1;
            trap_cause_d = pending_cause_q;
            pc_d         = TRAP_VECTOR;
            state_d      = ST_FETCH;
         end

         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed bench for pc_sequencer. Inputs change and outputs are sampled on
// the falling clock edge; obs_*[k] holds what was seen k cycles after the
// current instruction started in FETCH.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        instr_valid = 1'b0;
   logic [2:0]  unit_select = 3'd0;
   logic [31:0] jump_target = 32'd0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic [31:0] pc;
   logic        fetch_enable;
   logic        alu_enable;
   logic        alu_unconditional_jal_enable;
   logic        alu_unconditional_jalr_enable;
   logic        alu_branch_enable;
   logic        rd_write_enable;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [31:0] retired_count;

   int vectors = 0;
   int miscompares = 0;

   logic [3:0]  obs_en    [1:12];
   logic        obs_fetch [1:12];
   logic        obs_rd    [1:12];
   logic        obs_trap  [1:12];
   logic [1:0]  obs_cause [1:12];
   logic [31:0] obs_pc    [1:12];
   logic [31:0] obs_cnt   [1:12];

   pc_sequencer dut (
      .clock                         (clock),
      .reset                         (reset),
      .stall                         (stall),
      .instr_valid                   (instr_valid),
      .unit_select                   (unit_select),
      .jump_target                   (jump_target),
      .branch_taken                  (branch_taken),
      .branch_target                 (branch_target),
      .pc                            (pc),
      .fetch_enable                  (fetch_enable),
      .alu_enable                    (alu_enable),
      .alu_unconditional_jal_enable  (alu_unconditional_jal_enable),
      .alu_unconditional_jalr_enable (alu_unconditional_jalr_enable),
      .alu_branch_enable             (alu_branch_enable),
      .rd_write_enable               (rd_write_enable),
      .trap                          (trap),
      .trap_cause                    (trap_cause),
      .retired_count                 (retired_count)
   );

   // Clock / reset block
   always #5 clock = ~clock;

   // Driver tasks
   task automatic record(input int k);
      obs_en[k]    = {alu_enable, alu_unconditional_jal_enable,
                      alu_unconditional_jalr_enable, alu_branch_enable};
      obs_fetch[k] = fetch_enable;
      obs_rd[k]    = rd_write_enable;
      obs_trap[k]  = trap;
      obs_cause[k] = trap_cause;
      obs_pc[k]    = pc;
      obs_cnt[k]   = retired_count;
   endtask

   task automatic run_cycles(input int n);
      for (int k = 1; k <= n; k++) begin
         @(negedge clock);
         record(k);
      end
   endtask

   task automatic drive_instr(input logic [2:0] sel, input logic [31:0] jt,
                              input logic taken, input logic [31:0] bt);
      stall         = 1'b0;
      instr_valid   = 1'b1;
      unit_select   = sel;
      jump_target   = jt;
      branch_taken  = taken;
      branch_target = bt;
   endtask

   // Test tasks
   task automatic test_reset();
      reset = 1'b1;
      #3;
      vectors++;
      if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want 00000000", pc); end
      vectors++;
      if ({fetch_enable, alu_enable, alu_unconditional_jal_enable, alu_unconditional_jalr_enable,
           alu_branch_enable, rd_write_enable, trap} !== 7'b0) begin
         miscompares++; $display("FAIL reset_strobes got nonzero want 0");
      end
      vectors++;
      if (trap_cause !== 2'd0) begin miscompares++; $display("FAIL reset_cause got %0d want 0", trap_cause); end
      vectors++;
      if (retired_count !== 32'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", retired_count); end
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_alu();
      drive_instr(3'd0, 32'h0, 1'b0, 32'h0);
      run_cycles(4);
      vectors++;
      if (obs_fetch[1] !== 1'b1) begin miscompares++; $display("FAIL alu_fetch_c1 got %b want 1", obs_fetch[1]); end
      for (int k = 1; k <= 4; k++) begin
         vectors++;
         if (obs_en[k] !== ((k == 3) ? 4'b1000 : 4'b0000)) begin
            miscompares++; $display("FAIL alu_en_c%0d got %b want %b", k, obs_en[k], (k == 3) ? 4'b1000 : 4'b0000);
         end
      end
      vectors++;
      if (obs_pc[3] !== 32'h0) begin miscompares++; $display("FAIL alu_pc_c3 got %h want 00000000", obs_pc[3]); end
      vectors++;
      if (obs_pc[4] !== 32'h4) begin miscompares++; $display("FAIL alu_pc_c4 got %h want 00000004", obs_pc[4]); end
      vectors++;
      if ({obs_rd[3], obs_rd[4]} !== 2'b01) begin miscompares++; $display("FAIL alu_rd got %b want 01", {obs_rd[3], obs_rd[4]}); end
      vectors++;
      if (obs_cnt[4] !== 32'd1) begin miscompares++; $display("FAIL alu_count got %0d want 1", obs_cnt[4]); end
   endtask

   task automatic test_jalr();
      // Target 0x123 -> 0x122 after LSB clear, bit1 set: misaligned trap.
      drive_instr(3'd2, 32'h0000_0123, 1'b0, 32'h0);
      run_cycles(5);
      for (int k = 1; k <= 5; k++) begin
         vectors++;
         if (obs_en[k] !== ((k == 3) ? 4'b0010 : 4'b0000)) begin
            miscompares++; $display("FAIL jalr_bad_en_c%0d got %b want %b", k, obs_en[k], (k == 3) ? 4'b0010 : 4'b0000);
         end
      end
      vectors++;
      if (obs_pc[4] !== 32'h4) begin miscompares++; $display("FAIL jalr_bad_pc_hold got %h want 00000004", obs_pc[4]); end
      vectors++;
      if ({obs_trap[4], obs_trap[5]} !== 2'b01) begin miscompares++; $display("FAIL jalr_bad_trap got %b want 01", {obs_trap[4], obs_trap[5]}); end
      vectors++;
      if (obs_cause[5] !== 2'd1) begin miscompares++; $display("FAIL jalr_bad_cause got %0d want 1", obs_cause[5]); end
      vectors++;
      if (obs_pc[5] !== 32'h100) begin miscompares++; $display("FAIL jalr_bad_pc got %h want 00000100", obs_pc[5]); end
      vectors++;
      if ({obs_rd[3], obs_rd[4], obs_rd[5]} !== 3'b000) begin miscompares++; $display("FAIL jalr_bad_rd got %b want 000", {obs_rd[3], obs_rd[4], obs_rd[5]}); end
      vectors++;
      if (obs_cnt[5] !== 32'd1) begin miscompares++; $display("FAIL jalr_bad_count got %0d want 1", obs_cnt[5]); end

      drive_instr(3'd2, 32'h0000_0201, 1'b0, 32'h0);
      run_cycles(4);
      vectors++;
      if (obs_trap[1] !== 1'b0) begin miscompares++; $display("FAIL trap_one_cycle got %b want 0", obs_trap[1]); end
      vectors++;
      if (obs_cause[4] !== 2'd1) begin miscompares++; $display("FAIL cause_sticky got %0d want 1", obs_cause[4]); end
      vectors++;
      if (obs_pc[4] !== 32'h200) begin miscompares++; $display("FAIL jalr_pc got %h want 00000200", obs_pc[4]); end
      vectors++;
      if (obs_rd[4] !== 1'b1) begin miscompares++; $display("FAIL jalr_rd got %b want 1", obs_rd[4]); end
      vectors++;
      if (obs_cnt[4] !== 32'd2) begin miscompares++; $display("FAIL jalr_count got %0d want 2", obs_cnt[4]); end
   endtask

   task automatic test_branch();
      drive_instr(3'd1, 32'h0000_0008, 1'b0, 32'h0);
      run_cycles(4);
      vectors++;
      if (obs_en[3] !== 4'b0100) begin miscompares++; $display("FAIL jal_en got %b want 0100", obs_en[3]); end
      vectors++;
      if ({obs_pc[4], obs_rd[4]} !== {32'h8, 1'b1}) begin miscompares++; $display("FAIL jal_pc_rd got %h/%b want 00000008/1", obs_pc[4], obs_rd[4]); end

      drive_instr(3'd3, 32'h0, 1'b0, 32'h0000_0040);
      run_cycles(4);
      vectors++;
      if (obs_en[3] !== 4'b0001) begin miscompares++; $display("FAIL br_en got %b want 0001", obs_en[3]); end
      vectors++;
      if (obs_pc[4] !== 32'hC) begin miscompares++; $display("FAIL br_nt_pc got %h want 0000000c", obs_pc[4]); end
      vectors++;
      if (obs_rd[4] !== 1'b0) begin miscompares++; $display("FAIL br_nt_rd got %b want 0", obs_rd[4]); end
      vectors++;
      if (obs_cnt[4] !== 32'd4) begin miscompares++; $display("FAIL br_nt_count got %0d want 4", obs_cnt[4]); end

      drive_instr(3'd3, 32'h0, 1'b1, 32'h0000_0040);
      run_cycles(4);
      vectors++;
      if (obs_pc[4] !== 32'h40) begin miscompares++; $display("FAIL br_t_pc got %h want 00000040", obs_pc[4]); end
      vectors++;
      if (obs_rd[4] !== 1'b0) begin miscompares++; $display("FAIL br_t_rd got %b want 0", obs_rd[4]); end
      vectors++;
      if (obs_cnt[4] !== 32'd5) begin miscompares++; $display("FAIL br_t_count got %0d want 5", obs_cnt[4]); end
   endtask

   task automatic test_stall();
      // Three stall edges in FETCH, then two instr_valid-low edges in DECODE.
      drive_instr(3'd0, 32'h0, 1'b0, 32'h0);
      stall       = 1'b1;
      instr_valid = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clock);
         record(k);
         if (k == 3) stall = 1'b0;
         if (k == 6) instr_valid = 1'b1;
      end
      for (int k = 1; k <= 5; k++) begin
         vectors++;
         if (obs_fetch[k] !== ((k <= 4) ? 1'b1 : 1'b0)) begin
            miscompares++; $display("FAIL stall_fetch_c%0d got %b want %b", k, obs_fetch[k], (k <= 4) ? 1'b1 : 1'b0);
         end
      end
      for (int k = 1; k <= 9; k++) begin
         vectors++;
         if (obs_en[k] !== ((k == 8) ? 4'b1000 : 4'b0000)) begin
            miscompares++; $display("FAIL stall_en_c%0d got %b want %b", k, obs_en[k], (k == 8) ? 4'b1000 : 4'b0000);
         end
      end
      vectors++;
      if ({obs_pc[9], obs_rd[9]} !== {32'h44, 1'b1}) begin miscompares++; $display("FAIL stall_commit got %h/%b want 00000044/1", obs_pc[9], obs_rd[9]); end
      vectors++;
      if (obs_cnt[9] !== 32'd6) begin miscompares++; $display("FAIL stall_count got %0d want 6", obs_cnt[9]); end
   endtask

   task automatic test_illegal();
      drive_instr(3'd7, 32'h0, 1'b0, 32'h0);
      run_cycles(3);
      for (int k = 1; k <= 3; k++) begin
         vectors++;
         if (obs_en[k] !== 4'b0000) begin miscompares++; $display("FAIL ill_en_c%0d got %b want 0000", k, obs_en[k]); end
      end
      vectors++;
      if ({obs_trap[2], obs_trap[3]} !== 2'b01) begin miscompares++; $display("FAIL ill_trap got %b want 01", {obs_trap[2], obs_trap[3]}); end
      vectors++;
      if (obs_cause[3] !== 2'd2) begin miscompares++; $display("FAIL ill_cause got %0d want 2", obs_cause[3]); end
      vectors++;
      if (obs_pc[3] !== 32'h100) begin miscompares++; $display("FAIL ill_pc got %h want 00000100", obs_pc[3]); end
      vectors++;
      if ({obs_rd[3], obs_cnt[3]} !== {1'b0, 32'd6}) begin miscompares++; $display("FAIL ill_rd_count got %b/%0d want 0/6", obs_rd[3], obs_cnt[3]); end
   endtask

   task automatic test_wrap();
      force dut.retired_count = 32'hFFFF_FFFF;
      #1;
      release dut.retired_count;
      drive_instr(3'd0, 32'h0, 1'b0, 32'h0);
      run_cycles(4);
      vectors++;
      if (obs_cnt[3] !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_pre got %h want ffffffff", obs_cnt[3]); end
      vectors++;
      if (obs_cnt[4] !== 32'd0) begin miscompares++; $display("FAIL wrap_count got %h want 00000000", obs_cnt[4]); end
      vectors++;
      if (obs_pc[4] !== 32'h104) begin miscompares++; $display("FAIL wrap_pc got %h want 00000104", obs_pc[4]); end
   endtask

   task automatic test_reset_mid();
      drive_instr(3'd0, 32'h0, 1'b0, 32'h0);
      run_cycles(2);
      // Sequencer is in EXECUTE now; reset between clock edges.
      #1;
      reset = 1'b1;
      #1;
      vectors++;
      if (pc !== 32'h0) begin miscompares++; $display("FAIL rstmid_pc got %h want 00000000", pc); end
      vectors++;
      if (trap_cause !== 2'd0) begin miscompares++; $display("FAIL rstmid_cause got %0d want 0", trap_cause); end
      vectors++;
      if ({fetch_enable, alu_enable, alu_unconditional_jal_enable, alu_unconditional_jalr_enable,
           alu_branch_enable, rd_write_enable, trap} !== 7'b0) begin
         miscompares++; $display("FAIL rstmid_strobes got nonzero want 0");
      end
      @(negedge clock);
      @(negedge clock);
      vectors++;
      if ({alu_enable, rd_write_enable, retired_count} !== {1'b0, 1'b0, 32'd0}) begin
         miscompares++; $display("FAIL rstmid_abandon got %b/%b/%0d want 0/0/0", alu_enable, rd_write_enable, retired_count);
      end
      reset = 1'b0;
      drive_instr(3'd0, 32'h0, 1'b0, 32'h0);
      run_cycles(4);
      vectors++;
      if ({obs_pc[4], obs_cnt[4]} !== {32'h4, 32'd1}) begin
         miscompares++; $display("FAIL rstmid_restart got %h/%0d want 00000004/1", obs_pc[4], obs_cnt[4]);
      end
   endtask

   // Sequence and final report
   initial begin
      test_reset();
      test_alu();
      test_jalr();
      test_branch();
      test_stall();
      test_illegal();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
